// File: rtl/link_split_rx.sv
// Receive side of a split-simulation link: filters words by id, buffers them in a
// credit-controlled FIFO and replays them into the local link chain one per cycle.
module link_split_rx #(
    parameter logic [31:0] ID    = 32'd0,
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wen,
    input  logic [31:0] i_token,
    input  logic [31:0] i_clk_cnt,
    input  logic [31:0] i_id,
    input  logic        i_flush,
    input  logic        i_ready,
    output logic        o_wen,
    output logic [31:0] o_token,
    output logic [31:0] o_clk_cnt,
    output logic [31:0] o_id,
    output logic        o_credit,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt,
    output logic [15:0] o_miss_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = PW + 2;

    typedef enum logic {StInit, StRun} state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] pend_q, pend_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          credit_q, credit_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d, miss_cnt_q, miss_cnt_d;
    logic          wen_q, wen_d;
    logic [31:0]   token_q, token_d, clk_cnt_q, clk_cnt_d, id_q, id_d;
    logic [95:0]   mem_q [DEPTH];
    logic [95:0]   head;

    logic match, full, push, drop, miss, pop;

    assign match = (i_id == ID) || (i_id == 32'hFFFF_FFFF);
    assign full  = (count_q == CW'(DEPTH));
    // Flush suppresses both sides of the FIFO for the cycle; a suppressed push is not a drop.
    assign push  = i_wen && match && !full && !i_flush;
    assign drop  = i_wen && match && full && !i_flush;
    assign miss  = i_wen && !match;
    assign pop   = (count_q != '0) && i_ready && !i_flush;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q - NW'(pend_q != '0) + NW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        credit_d   = (pend_q != '0);
        overflow_d = overflow_q || drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        miss_cnt_d = (miss && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
        wen_d      = pop;
        token_d    = token_q;
        clk_cnt_d  = clk_cnt_q;
        id_d       = id_q;

        if (pop) begin
            token_d   = head[95:64];
            clk_cnt_d = head[63:32];
            id_d      = head[31:0];
        end

        // Every discarded entry hands its slot back to the sender.
        if (i_flush) begin
            pend_d   = pend_d + NW'(count_q);
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        if (state_q == StInit && pend_q == '0) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StInit;
            pend_q     <= NW'(DEPTH);
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            miss_cnt_q <= '0;
            wen_q      <= 1'b0;
            token_q    <= '0;
            clk_cnt_q  <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wen_q      <= wen_d;
            token_q    <= token_d;
            clk_cnt_q  <= clk_cnt_d;
            id_q       <= id_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_token, i_clk_cnt, i_id};
        end
    end

    assign o_wen      = wen_q;
    assign o_token    = token_q;
    assign o_clk_cnt  = clk_cnt_q;
    assign o_id       = id_q;
    assign o_credit   = credit_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_miss_cnt = miss_cnt_q;

endmodule
